// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit saturating counter
// encodings and the default BTB depth.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,  // strongly not-taken
        CTR_WNT = 2'b01,  // weakly not-taken
        CTR_WT  = 2'b10,  // weakly taken
        CTR_ST  = 2'b11   // strongly taken
    } ctr_t;

    localparam int unsigned BP_ENTRIES = 16;

endpackage : branch_predictor_pkg

// File: rtl/branch_predictor_sat_ctr2.sv
// bp_sat_ctr2: next-state logic for a 2-bit saturating direction counter.
// Purely combinational; load has priority over inc, inc over dec.
// Ports:
//   i_ctr      current counter value
//   i_inc      step towards strongly taken (saturates at CTR_ST)
//   i_dec      step towards strongly not-taken (saturates at CTR_SNT)
//   i_load     replace the counter with i_load_val
//   i_load_val value used on load
//   o_ctr      next counter value
module bp_sat_ctr2
    import branch_predictor_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_load,
    input  ctr_t i_load_val,
    output ctr_t o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_load) begin
            o_ctr = i_load_val;
        end else if (i_inc) begin
            case (i_ctr)
                CTR_SNT: o_ctr = CTR_WNT;
                CTR_WNT: o_ctr = CTR_WT;
                default: o_ctr = CTR_ST;
            endcase
        end else if (i_dec) begin
            case (i_ctr)
                CTR_ST:  o_ctr = CTR_WT;
                CTR_WT:  o_ctr = CTR_WNT;
                default: o_ctr = CTR_SNT;
            endcase
        end
    end

endmodule : bp_sat_ctr2

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters that
// supplies PreBranch/PreAddr to the PC stage.
// Lookup is combinational from registered state; training is registered.
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   ce               fetch enable (0 forces PreBranch=0)
//   PC               current fetch address (PC[1:0] ignored)
//   PreBranch        predict taken for PC
//   PreAddr          predicted target, 0 when PreBranch=0
//   upd_valid        EX reports a resolved control-flow instruction
//   upd_pc           PC of the resolved instruction
//   upd_taken        actual direction
//   upd_target       actual target
//   upd_pred         prediction carried with the instruction
//   upd_pred_addr    predicted target carried with the instruction
//   mispredict       one-cycle pulse after a mispredicted update
//   mispred_cnt      saturating misprediction count since reset
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES  = BP_ENTRIES,
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] PC,
    output logic        PreBranch,
    output logic [31:0] PreAddr,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred,
    input  logic [31:0] upd_pred_addr,
    output logic        mispredict,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    ctr_t             r_ctr    [ENTRIES];

    logic        r_mispredict;
    logic [31:0] r_mispred_cnt;

    // Lookup path
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_pred_taken;

    assign w_idx        = PC[IDX_W+1:2];
    assign w_tag        = PC[31:IDX_W+2];
    assign w_hit        = ce && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pred_taken = w_hit && r_ctr[w_idx][1];

    assign PreBranch = w_pred_taken;
    assign PreAddr   = w_pred_taken ? r_target[w_idx] : '0;

    // Update path
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic             w_mispred;
    ctr_t             w_ctr_next;

    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_utag = upd_pc[31:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    // A correctly predicted direction can still be wrong on the target.
    assign w_mispred = upd_valid &&
                       ((upd_pred != upd_taken) ||
                        (upd_taken && upd_pred && (upd_pred_addr != upd_target)));

    bp_sat_ctr2 u_sat_ctr (
        .i_ctr      (r_ctr[w_uidx]),
        .i_inc      (w_uhit && upd_taken),
        .i_dec      (w_uhit && !upd_taken),
        .i_load     (!w_uhit && upd_taken),
        .i_load_val (ctr_t'(CTR_INIT)),
        .o_ctr      (w_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WNT;
            end
        end else if (upd_valid) begin
            // Miss + not-taken leaves the entry untouched; every other case
            // writes the counter, and taken outcomes also refresh the target.
            if (w_uhit || upd_taken) begin
                r_ctr[w_uidx] <= w_ctr_next;
            end
            if (upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mispredict  <= 1'b0;
            r_mispred_cnt <= '0;
        end else begin
            r_mispredict <= w_mispred;
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign mispred_cnt = r_mispred_cnt;

    // Word-aligned addresses: the low two bits never participate.
    logic w_unused_lsbs;
    assign w_unused_lsbs = &{PC[1:0], upd_pc[1:0]};

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] PC;
    logic        PreBranch;
    logic [31:0] PreAddr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;
    logic [31:0] upd_pred_addr;
    logic        mispredict;
    logic [31:0] mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .ENTRIES  (16),
        .IDX_W    (4),
        .CTR_INIT (2'b10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .PC            (PC),
        .PreBranch     (PreBranch),
        .PreAddr       (PreAddr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_pred      (upd_pred),
        .upd_pred_addr (upd_pred_addr),
        .mispredict    (mispredict),
        .mispred_cnt   (mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one update for a single edge, then drop upd_valid.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic pred, input logic [31:0] paddr);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_taken     = taken;
        upd_target    = tgt;
        upd_pred      = pred;
        upd_pred_addr = paddr;
        tick();
        upd_valid     = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ce = 1'b1; PC = 32'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred = 1'b0; upd_pred_addr = '0;

        // Reset
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_prebranch", {31'b0, PreBranch}, 32'd0);
        check("rst_preaddr", PreAddr, 32'h0);
        check("rst_cnt", mispred_cnt, 32'd0);
        check("rst_mispredict", {31'b0, mispredict}, 32'd0);

        // Allocate 0x40 -> 0x100, ctr=10
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        check("alloc_prebranch", {31'b0, PreBranch}, 32'd1);
        check("alloc_preaddr", PreAddr, 32'h100);
        check("alloc_mispredict", {31'b0, mispredict}, 32'd1);
        check("alloc_cnt", mispred_cnt, 32'd1);
        tick();
        check("pulse_clears", {31'b0, mispredict}, 32'd0);

        // Hysteresis: 10 -> 01 -> 10
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        check("hyst_nt_prebranch", {31'b0, PreBranch}, 32'd0);
        check("hyst_nt_preaddr", PreAddr, 32'h0);
        check("hyst_nt_cnt", mispred_cnt, 32'd2);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        check("hyst_t_prebranch", {31'b0, PreBranch}, 32'd1);
        check("hyst_t_cnt", mispred_cnt, 32'd3);

        // Saturation: 4 correct taken -> 11, then one not-taken -> 10
        for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        check("sat_no_mispredict", {31'b0, mispredict}, 32'd0);
        check("sat_cnt_hold", mispred_cnt, 32'd3);
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        check("sat_nt_still_taken", {31'b0, PreBranch}, 32'd1);
        check("sat_nt_cnt", mispred_cnt, 32'd4);

        // ce=0 masks a hit
        ce = 1'b0; #1;
        check("ce0_prebranch", {31'b0, PreBranch}, 32'd0);
        check("ce0_preaddr", PreAddr, 32'h0);
        ce = 1'b1; #1;

        // Bring ctr to 01, then same-cycle lookup/update 01 -> 10
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        check("to_wnt_prebranch", {31'b0, PreBranch}, 32'd0);
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
        upd_target = 32'h100; upd_pred = 1'b0; upd_pred_addr = 32'h0;
        #1;
        check("same_cycle_old", {31'b0, PreBranch}, 32'd0);
        tick();
        upd_valid = 1'b0;
        check("same_cycle_new", {31'b0, PreBranch}, 32'd1);
        check("same_cycle_cnt", mispred_cnt, 32'd6);

        // Target mismatch with correct direction
        upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
        check("tgt_mispredict", {31'b0, mispredict}, 32'd1);
        check("tgt_cnt", mispred_cnt, 32'd7);
        check("tgt_new_addr", PreAddr, 32'h200);

        // Alias: 0x80 shares index 0 with 0x40
        upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
        check("alias_old_miss", {31'b0, PreBranch}, 32'd0);
        PC = 32'h80; #1;
        check("alias_new_hit", {31'b0, PreBranch}, 32'd1);
        check("alias_new_addr", PreAddr, 32'h300);

        // Miss + not-taken: no state change, correct prediction
        upd(32'hC4, 1'b0, 32'h0, 1'b0, 32'h0);
        check("miss_nt_mispredict", {31'b0, mispredict}, 32'd0);
        check("miss_nt_cnt", mispred_cnt, 32'd8);
        check("miss_nt_keeps_0x80", PreAddr, 32'h300);
        PC = 32'hC4; #1;
        check("miss_nt_no_alloc", {31'b0, PreBranch}, 32'd0);

        // Reset coinciding with an update discards it
        rst = 1'b0;
        upd(32'hC4, 1'b1, 32'h400, 1'b0, 32'h0);
        rst = 1'b1; #1;
        check("rst_upd_prebranch", {31'b0, PreBranch}, 32'd0);
        check("rst_upd_cnt", mispred_cnt, 32'd0);
        check("rst_upd_mispredict", {31'b0, mispredict}, 32'd0);
        PC = 32'h80; #1;
        check("rst_clears_entries", {31'b0, PreBranch}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule : tb_branch_predictor
